systolic_mm_array: RTL and testbench
====================================

# systolic_mm_array

Parametrised N×N output-stationary systolic matrix multiplier computing C = A·B for square N×N operand matrices. It is the successor to the fixed 3×3 systolic top. It adds:
- generic size and operand width,
- internal input skewing, so the host feeds unskewed column/row vectors,
- valid/ready handshakes on both operand input and result output,
- a sequenced load/compute/drain flow.

It sits between the operand buffers and the result writeback path.

## Interface
- `N`, 4, array dimension (rows = cols = reduction length); N ≥ 2
- `DW`, 8, operand width
- `ACCW`, 2*DW+$clog2(N), accumulator/result width
- `clk`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a new product; sampled only in IDLE
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  array accepts an operand beat
- `a_col`  in  N*DW  column k of A; lane i = A[i][k]
- `b_row`  in  N*DW  row k of B; lane j = B[k][j]
- `out_valid`  out  1  result row valid
- `out_ready`  in  1  downstream accepts result row
- `out_data`  out  N*ACCW  row r of C; lane j = C[r][j]
- `out_row`  out  $clog2(N)  index r of the row on out_data
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when the last result row is accepted

## Operation
- FSM states:
  - IDLE: on `start`, go to LOAD.
  - LOAD: after N accepted beats, go to COMPUTE.
  - COMPUTE: after 2N-1 cycles, go to DRAIN.
  - DRAIN: after N accepted rows, go to IDLE.
- On `start`:
  - all N² accumulators and the skew/PE pipeline registers clear to 0;
  - the beat counter k and the row counter r reset to 0.
- `in_ready` is high only in LOAD. A beat is accepted when `in_valid && in_ready`; beat k carries column k of A and row k of B.
- Skew:
  - A lane i is delayed i cycles before entering PE(i,0).
  - B lane j is delayed j cycles before entering PE(0,j).
- PE(i,j), each cycle:
  - `acc += a*b`;
  - forwards a to the right and b downward through one register each.
- Bubbles: a cycle in LOAD without an accepted beat injects zeros on both edges. Zeros contribute nothing to the sums, so `in_valid` gaps are legal and the result is unchanged.
- Arithmetic:
  - full-width product (2*DW) is sign- or zero-extended to ACCW, per Configuration;
  - accumulation is modulo 2^ACCW;
  - the default ACCW cannot overflow.
- DRAIN:
  - `out_valid` is high and presents row r with `out_row = r`;
  - the row advances on `out_valid && out_ready`;
  - while `out_ready` is low, `out_data`/`out_row` hold stable.
- `done` pulses in the cycle after the row N-1 handshake, coincident with the return to IDLE.
- Ignored inputs:
  - `start` in any state other than IDLE is ignored;
  - `in_valid` outside LOAD is ignored.
- `start` and `in_valid` high in the same IDLE cycle: only `start` takes effect; that beat is not accepted.

## Timing
- Reset values (reset_n low, asynchronous): state IDLE; `in_ready`, `out_valid`, `busy`, `done` = 0; `out_data`, `out_row` = 0; all accumulators and pipeline registers = 0.
- Reset mid-operation aborts immediately; no `done` is produced and partial results are discarded.
- `start` sampled at edge t: `busy` and `in_ready` are high from t+1.
- Last beat accepted at edge t:
  - `in_ready` is low from t+1;
  - COMPUTE occupies t+1 … t+2N-1;
  - `out_valid` is first high at t+2N with row 0.
- Minimum total latency, from `start` to `done` with no stalls: 1 + N + (2N-1) + N + 1 cycles (4N+1); 17 for N=4.
- Back-to-back operation: a new `start` is accepted the cycle after `done`.

## Configuration
- `SYSTOLIC_SIGNED_EN`
  - Defined: a_col/b_row lanes are two's-complement signed; products and accumulators are signed; out_data lanes are signed.
  - Undefined (default): all operands and results are unsigned.
- Width and latency are identical in both builds.

## Test plan
- Identity (N=4, DW=8): A = I, B = [[1..4],[5..8],[9..12],[13..16]], beats back-to-back, `out_ready` = 1.
  - Rows out in order r = 0..3 equal to B.
  - First `out_valid` exactly 2N = 8 cycles after the last beat.
  - `done` at cycle 17 after `start`.
- Max unsigned: all operands 255.
  - Every C lane = 4·255·255 = 260100, with no overflow in 18 bits.
- Signed build (`SYSTOLIC_SIGNED_EN`): all A = -128, all B = -128 → every lane = 65536. With A = -1 and B = 3 → every lane = -12 (0x3FFF4).
- Bubbles and backpressure:
  - `in_valid` toggled 1,0,0,1,1,0,1 during load must give the same C as the back-to-back case.
  - `out_ready` held low 5 cycles on row 2 must keep `out_data` and `out_row` = 2 stable, with no row lost or duplicated.
- Protocol edges:
  - `start` pulsed in LOAD and in DRAIN is ignored.
  - `start` and `in_valid` high together in IDLE must not consume a beat.
  - `reset_n` low mid-COMPUTE returns to IDLE with all outputs 0; a following full run gives correct results.

Source files
------------

// File: rtl/systolic_mm_array.sv
// rtl/systolic_mm_array.sv - parametrised N x N output-stationary systolic matrix multiplier
//
// Computes C = A * B for square N x N operands. The host streams N beats;
// beat k carries column k of A and row k of B. The block skews them internally,
// runs the PE grid for 2N-1 more cycles, then drains C one row at a time.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin a new product (sampled only in IDLE)
//   in_valid / in_ready   operand beat handshake (in_ready only in LOAD)
//   a_col [N*DW]          lane i = A[i][k]
//   b_row [N*DW]          lane j = B[k][j]
//   out_valid / out_ready result row handshake (out_valid only in DRAIN)
//   out_data [N*ACCW]     lane j = C[r][j]
//   out_row               row index r on out_data
//   busy                  high in any state other than IDLE
//   done                  one-cycle pulse after the last row is accepted
//
// Build option: SYSTOLIC_SIGNED_EN - when defined, operands, products and
// results are two's-complement signed; otherwise everything is unsigned.

module systolic_mm_array #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int ACCW = 2*DW + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      a_col,
    input  logic [N*DW-1:0]      b_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*ACCW-1:0]    out_data,
    output logic [$clog2(N)-1:0] out_row,
    output logic                 busy,
    output logic                 done
);

    localparam int RW = $clog2(N);
    localparam int CW = $clog2(2*N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    // Shared counter: beats in LOAD, cycles in COMPUTE, rows in DRAIN.
    logic [CW-1:0] cnt;

    logic beat_acc;
    logic row_acc;
    logic load_last;
    logic comp_last;
    logic drain_last;
    logic clr;
    logic pe_en;

    assign in_ready   = (state == LOAD);
    assign out_valid  = (state == DRAIN);
    assign busy       = (state != IDLE);
    assign beat_acc   = in_valid && in_ready;
    assign row_acc    = out_valid && out_ready;
    assign load_last  = beat_acc && (cnt == CW'(N-1));
    assign comp_last  = (state == COMPUTE) && (cnt == CW'(2*N-2));
    assign drain_last = row_acc && (cnt == CW'(N-1));
    assign clr        = (state == IDLE) && start;
    // The grid only moves while operands can still be in flight; in DRAIN
    // the accumulators hold so rows read out stay stable.
    assign pe_en      = (state == LOAD) || (state == COMPUTE);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = LOAD;
            LOAD:    if (load_last)  state_nxt = COMPUTE;
            COMPUTE: if (comp_last)  state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= drain_last;
            if (clr) begin
                cnt <= '0;
            end else begin
                case (state)
                    LOAD:    if (beat_acc) cnt <= load_last ? '0 : cnt + CW'(1);
                    COMPUTE: cnt <= comp_last ? '0 : cnt + CW'(1);
                    DRAIN:   if (row_acc)  cnt <= drain_last ? '0 : cnt + CW'(1);
                    default: cnt <= '0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Skew and PE grid
    // ------------------------------------------------------------------
    logic [DW-1:0]     inj_a    [N];
    logic [DW-1:0]     inj_b    [N];
    logic [DW-1:0]     ent_a    [N];
    logic [DW-1:0]     ent_b    [N];
    logic [DW-1:0]     skew_a   [N][N-1];
    logic [DW-1:0]     skew_b   [N][N-1];
    logic [DW-1:0]     a_reg    [N][N];
    logic [DW-1:0]     b_reg    [N][N];
    logic [DW-1:0]     a_in     [N][N];
    logic [DW-1:0]     b_in     [N][N];
    logic [2*DW-1:0]   prod     [N][N];
    logic [ACCW-1:0]   prod_ext [N][N];
    logic [ACCW-1:0]   acc      [N][N];

    // A LOAD cycle without an accepted beat injects zeros, which add nothing
    // to any sum; A[i][k] and B[k][j] of one beat always travel i+j stages,
    // so bubbles never misalign operand pairs.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            inj_a[i] = beat_acc ? a_col[i*DW +: DW] : '0;
            inj_b[i] = beat_acc ? b_row[i*DW +: DW] : '0;
        end
        ent_a[0] = inj_a[0];
        ent_b[0] = inj_b[0];
        for (int i = 1; i < N; i++) begin
            ent_a[i] = skew_a[i][i-1];
            ent_b[i] = skew_b[i][i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = ent_a[i];
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = a_reg[i][j-1];
            end
        end
        for (int j = 0; j < N; j++) begin
            b_in[0][j] = ent_b[j];
            for (int i = 1; i < N; i++) begin
                b_in[i][j] = b_reg[i-1][j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
`ifdef SYSTOLIC_SIGNED_EN
                prod[i][j]     = (2*DW)'($signed(a_in[i][j])) * (2*DW)'($signed(b_in[i][j]));
                prod_ext[i][j] = ACCW'($signed(prod[i][j]));
`else
                prod[i][j]     = (2*DW)'(a_in[i][j]) * (2*DW)'(b_in[i][j]);
                prod_ext[i][j] = ACCW'(prod[i][j]);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                for (int d = 0; d < N-1; d++) begin
                    skew_a[i][d] <= '0;
                    skew_b[i][d] <= '0;
                end
                for (int j = 0; j < N; j++) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
            end
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                for (int d = 0; d < N-1; d++) begin
                    skew_a[i][d] <= '0;
                    skew_b[i][d] <= '0;
                end
                for (int j = 0; j < N; j++) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
            end
        end else if (pe_en) begin
            for (int i = 0; i < N; i++) begin
                skew_a[i][0] <= inj_a[i];
                skew_b[i][0] <= inj_b[i];
                for (int d = 1; d < N-1; d++) begin
                    skew_a[i][d] <= skew_a[i][d-1];
                    skew_b[i][d] <= skew_b[i][d-1];
                end
                for (int j = 0; j < N; j++) begin
                    a_reg[i][j] <= a_in[i][j];
                    b_reg[i][j] <= b_in[i][j];
                    acc[i][j]   <= acc[i][j] + prod_ext[i][j];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Result row mux
    // ------------------------------------------------------------------
    always_comb begin
        out_row  = out_valid ? cnt[RW-1:0] : '0;
        out_data = '0;
        for (int j = 0; j < N; j++) begin
            out_data[j*ACCW +: ACCW] = out_valid ? acc[cnt[RW-1:0]][j] : '0;
        end
    end

endmodule

// File: tb/tb_systolic_mm_array.sv
// tb/tb_systolic_mm_array.sv - directed self-checking bench for systolic_mm_array
module tb_systolic_mm_array;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int ACCW = 2*DW + $clog2(N);

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*DW-1:0]      a_col;
    logic [N*DW-1:0]      b_row;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*ACCW-1:0]    out_data;
    logic [$clog2(N)-1:0] out_row;
    logic                 busy;
    logic                 done;

    systolic_mm_array #(.N(N), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_count = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_count <= done_count + 1;
    end

    logic [DW-1:0]     ma [N][N];
    logic [DW-1:0]     mb [N][N];
    logic [N*ACCW-1:0] exp_row [N];
    logic [N*ACCW-1:0] got [N];

    int start_cyc, last_beat_cyc, first_valid_cyc, done_cyc;
    int beats, rows, done_before;
    bit stable_ok, order_ok, done_seen, busy_after_start;

    task automatic set_identity_b();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? 8'd1 : 8'd0;
                mb[i][j] = 8'(i*N + j + 1);
                exp_row[i][j*ACCW +: ACCW] = ACCW'(i*N + j + 1);
            end
    endtask

    task automatic set_uniform(input logic [7:0] av, input logic [7:0] bv, input logic [ACCW-1:0] cv);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = av;
                mb[i][j] = bv;
                exp_row[i][j*ACCW +: ACCW] = cv;
            end
    endtask

    // A = [[1,2,3,4],[0,1,0,1],[2,0,2,0],[1,1,1,1]], B = [[1..4],[5..8],[9..12],[13..16]]
    // C = [[90,100,110,120],[18,20,22,24],[20,24,28,32],[28,32,36,40]]
    task automatic set_general();
        int av [N][N];
        int cv [N][N];
        av = '{'{1,2,3,4}, '{0,1,0,1}, '{2,0,2,0}, '{1,1,1,1}};
        cv = '{'{90,100,110,120}, '{18,20,22,24}, '{20,24,28,32}, '{28,32,36,40}};
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 8'(av[i][j]);
                mb[i][j] = 8'(i*N + j + 1);
                exp_row[i][j*ACCW +: ACCW] = ACCW'(cv[i][j]);
            end
    endtask

    task automatic do_start(input bit with_valid);
        @(negedge clk);
        start    = 1'b1;
        in_valid = with_valid;
        a_col    = {N{8'd99}};
        b_row    = {N{8'd99}};
        @(posedge clk);
        #1;
        start_cyc        = cyc;
        busy_after_start = busy && in_ready;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [6:0] pat, input int plen, input bit poke);
        int  idx = 0;
        int  guard = 0;
        bit  v, acc;
        beats = 0;
        while (beats < N && guard < 50) begin
            @(negedge clk);
            guard++;
            v = (plen == 0) ? 1'b1 : pat[idx % plen];
            idx++;
            in_valid = v;
            for (int i = 0; i < N; i++) begin
                a_col[i*DW +: DW] = ma[i][beats];
                b_row[i*DW +: DW] = mb[beats][i];
            end
            start = poke && (guard == 2);
            acc = v && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                beats++;
                last_beat_cyc = cyc;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_drain(input int stall_row, input int stall_len, input bit poke);
        int guard = 0;
        int stalled = 0;
        bit first = 1'b1;
        logic [N*ACCW-1:0] hold_d;
        logic [$clog2(N)-1:0] hold_r;
        rows = 0;
        stable_ok = 1'b1;
        order_ok = 1'b1;
        while (rows < N && guard < 200) begin
            @(negedge clk);
            guard++;
            start = 1'b0;
            if (out_valid) begin
                if (first) begin
                    first_valid_cyc = cyc;
                    first = 1'b0;
                    start = poke;
                end
                if (out_row == stall_row && stalled < stall_len) begin
                    if (stalled == 0) begin
                        hold_d = out_data;
                        hold_r = out_row;
                    end else if (out_data !== hold_d || out_row !== hold_r) begin
                        stable_ok = 1'b0;
                    end
                    stalled++;
                    out_ready = 1'b0;
                end else begin
                    if (stalled > 0 && rows == stall_row && (out_data !== hold_d || out_row !== hold_r))
                        stable_ok = 1'b0;
                    out_ready = 1'b1;
                    if (out_row !== rows[$clog2(N)-1:0]) order_ok = 1'b0;
                    got[rows] = out_data;
                    rows++;
                end
            end else begin
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        done_seen = done;
        done_cyc  = cyc;
        @(negedge clk);
    endtask

    task automatic run_full(input logic [6:0] pat, input int plen, input int stall_row, input int stall_len,
                            input bit poke_load, input bit poke_drain, input bit start_with_valid);
        done_before = done_count;
        do_start(start_with_valid);
        do_load(pat, plen, poke_load);
        do_drain(stall_row, stall_len, poke_drain);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_col = '0; b_row = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, busy, done} !== 4'b0000)
            $display("FAIL reset_ctrl got %b exp 0000", {in_ready, out_valid, busy, done});
        else n_pass++;
        n_checks++;
        if (out_data !== '0 || out_row !== '0)
            $display("FAIL reset_data got %h/%0d exp 0/0", out_data, out_row);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        set_identity_b();
        run_full(7'd0, 0, -1, 0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (busy_after_start !== 1'b1) $display("FAIL ident_busy got %b exp 1", busy_after_start);
        else n_pass++;
        n_checks++;
        if (beats != N || rows != N || order_ok !== 1'b1)
            $display("FAIL ident_counts got beats %0d rows %0d order %b exp %0d %0d 1", beats, rows, order_ok, N, N);
        else n_pass++;
        for (int r = 0; r < N; r++) begin
            n_checks++;
            if (got[r] !== exp_row[r]) $display("FAIL ident_row%0d got %h exp %h", r, got[r], exp_row[r]);
            else n_pass++;
        end
        // out_valid in the 2N-th cycle after the beat cycle: 2N-1 edges later.
        n_checks++;
        if (first_valid_cyc - last_beat_cyc != 2*N-1)
            $display("FAIL ident_first_valid got %0d exp %0d", first_valid_cyc - last_beat_cyc, 2*N-1);
        else n_pass++;
        // done in cycle 4N+1 counting the start cycle as cycle 1: 4N-1 edges after the start edge.
        n_checks++;
        if (done_seen !== 1'b1 || done_cyc - start_cyc != 4*N-1)
            $display("FAIL ident_done got %b at %0d exp 1 at %0d", done_seen, done_cyc - start_cyc, 4*N-1);
        else n_pass++;
        n_checks++;
        if (done_count - done_before != 1 || busy !== 1'b0)
            $display("FAIL ident_done_once got %0d busy %b exp 1 busy 0", done_count - done_before, busy);
        else n_pass++;
    endtask

    task automatic test_max();
        set_uniform(8'd255, 8'd255, ACCW'(260100));
        run_full(7'd0, 0, -1, 0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < N; r++) begin
            n_checks++;
            if (got[r] !== exp_row[r]) $display("FAIL max_row%0d got %h exp %h", r, got[r], exp_row[r]);
            else n_pass++;
        end
    endtask

    task automatic test_signed_patterns();
        set_uniform(8'h80, 8'h80, ACCW'(65536));
        run_full(7'd0, 0, -1, 0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got[0] !== exp_row[0] || got[3] !== exp_row[3])
            $display("FAIL neg128_rows got %h %h exp %h", got[0], got[3], exp_row[0]);
        else n_pass++;
`ifdef SYSTOLIC_SIGNED_EN
        set_uniform(8'hFF, 8'd3, 18'h3FFF4);
`else
        set_uniform(8'hFF, 8'd3, ACCW'(3060));
`endif
        run_full(7'd0, 0, -1, 0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got[1] !== exp_row[1] || got[2] !== exp_row[2])
            $display("FAIL minus1x3_rows got %h %h exp %h", got[1], got[2], exp_row[1]);
        else n_pass++;
    endtask

    task automatic test_general();
        set_general();
        run_full(7'd0, 0, -1, 0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < N; r++) begin
            n_checks++;
            if (got[r] !== exp_row[r]) $display("FAIL general_row%0d got %h exp %h", r, got[r], exp_row[r]);
            else n_pass++;
        end
    endtask

    task automatic test_bubbles();
        set_general();
        // in_valid sequence 1,0,0,1,1,0,1 (bit 0 first)
        run_full(7'b1011001, 7, -1, 0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < N; r++) begin
            n_checks++;
            if (got[r] !== exp_row[r]) $display("FAIL bubble_row%0d got %h exp %h", r, got[r], exp_row[r]);
            else n_pass++;
        end
        n_checks++;
        if (first_valid_cyc - last_beat_cyc != 2*N-1)
            $display("FAIL bubble_first_valid got %0d exp %0d", first_valid_cyc - last_beat_cyc, 2*N-1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        set_identity_b();
        run_full(7'd0, 0, 2, 5, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (stable_ok !== 1'b1 || order_ok !== 1'b1 || rows != N)
            $display("FAIL bp_stable got stable %b order %b rows %0d exp 1 1 %0d", stable_ok, order_ok, rows, N);
        else n_pass++;
        for (int r = 0; r < N; r++) begin
            n_checks++;
            if (got[r] !== exp_row[r]) $display("FAIL bp_row%0d got %h exp %h", r, got[r], exp_row[r]);
            else n_pass++;
        end
        n_checks++;
        if (done_seen !== 1'b1 || done_count - done_before != 1)
            $display("FAIL bp_done got %b count %0d exp 1 1", done_seen, done_count - done_before);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        set_general();
        run_full(7'd0, 0, -1, 0, 1'b1, 1'b1, 1'b0);
        for (int r = 0; r < N; r++) begin
            n_checks++;
            if (got[r] !== exp_row[r]) $display("FAIL startign_row%0d got %h exp %h", r, got[r], exp_row[r]);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done_count - done_before != 1 || first_valid_cyc - last_beat_cyc != 2*N-1)
            $display("FAIL startign_state got busy %b dones %0d lat %0d exp 0 1 %0d",
                     busy, done_count - done_before, first_valid_cyc - last_beat_cyc, 2*N-1);
        else n_pass++;
    endtask

    task automatic test_start_with_valid();
        set_identity_b();
        run_full(7'd0, 0, -1, 0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < N; r++) begin
            n_checks++;
            if (got[r] !== exp_row[r]) $display("FAIL startvalid_row%0d got %h exp %h", r, got[r], exp_row[r]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        set_general();
        done_before = done_count;
        do_start(1'b0);
        do_load(7'd0, 0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, done} !== 4'b0000 || out_data !== '0 || out_row !== '0)
            $display("FAIL midreset_outputs got %b %h exp 0000 0", {in_ready, out_valid, busy, done}, out_data);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done_count != done_before)
            $display("FAIL midreset_idle got busy %b dones %0d exp 0 0", busy, done_count - done_before);
        else n_pass++;
        set_identity_b();
        run_full(7'd0, 0, -1, 0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < N; r++) begin
            n_checks++;
            if (got[r] !== exp_row[r]) $display("FAIL midreset_row%0d got %h exp %h", r, got[r], exp_row[r]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_max();
        test_signed_patterns();
        test_general();
        test_bubbles();
        test_backpressure();
        test_start_ignored();
        test_start_with_valid();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
